serial_adder: RTL

- Bit-serial ripple adder: one full-adder cell plus a carry flip-flop computes A + B + cin over WIDTH clock cycles, LSB first.
- Performs the inverse operation of the team's full-subtractor datapath. Adding the subtrahend back to a difference reconstructs the minuend, so the verification environment uses it to cross-check subtractor results.
- Sits between a register-file style source (start/operands) and a consumer that samples sum on done.

---
 rtl/serial_adder.sv | 66 ++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder computing a + b + cin over WIDTH cycles
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] sa, sb, sr, sr_n;
    logic [CNT_W-1:0] cnt;
    logic             carry, carry_n, s, last;

    // full-adder cell on the current LSBs, result bit shifted in at the MSB, next state
    always_comb begin
        s       = sa[0] ^ sb[0] ^ carry;
        carry_n = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));
        sr_n    = WIDTH'({s, sr} >> 1);
        last    = cnt == CNT_W'(WIDTH - 1);
        state_n = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    end

    // state register, operand shifters, carry FF and result capture on the final bit
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            state <= state_n;
            if (state != RUN && start) begin
                sa    <= a;
                sb    <= b;
                carry <= cin;
                cnt   <= '0;
            end else if (state == RUN) begin
                sa    <= sa >> 1;
                sb    <= sb >> 1;
                sr    <= sr_n;
                carry <= carry_n;
                cnt   <= cnt + CNT_W'(1);
                if (last) begin
                    sum  <= sr_n;
                    cout <= carry_n;
                end
            end
        end
    end

    assign busy = state == RUN;
    assign done = state == DONE;
endmodule
